alu_result_fifo: RTL

Registered output buffer sitting directly downstream of the 32-bit ALU function units (OR, AND, adder, …). Accepts one result word per cycle from the ALU result mux over a valid/ready handshake, tags it with the opcode and zero/negative/parity flags, and holds it in a small FIFO until the consumer (register-file writeback) accepts it. It decouples the combinational ALU from writeback stalls without dropping results.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_flags.sv | 20 ++
 rtl/alu_result_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode tags and the per-result flag bundle.
// Pure declarations, no logic.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;

    localparam logic [ALU_OPW-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_OPW-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_OPW-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 4'd3;
    localparam logic [ALU_OPW-1:0] ALU_XOR = 4'd4;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } alu_flags_t;

endpackage

// File: rtl/alu_flags.sv
// Result flag generator: zero / negative / parity of one ALU word.
// Latency: combinational. Backpressure: none, pure function of its input.
// Sits on the push path so flags are frozen with the stored entry.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output alu_flags_t       flags
);

    always_comb begin
        flags        = '0;
        flags.zero   = ~|data;
        flags.neg    = data[WIDTH-1];
        flags.parity = ^data;
    end

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result buffer: tags each accepted word with opcode and flags, queues DEPTH entries.
// Latency: 1 cycle push to out_valid, no fall-through; one push and one pop per cycle sustained.
// Backpressure: in_ready low only when full, derived from registered count (no out_ready->in_ready path).
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic [OPW-1:0]             in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [OPW-1:0]             out_op,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_parity,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                accepted_total
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      total_q, total_d;

    logic [WIDTH-1:0] result_mem_q [DEPTH];
    logic [OPW-1:0]   op_mem_q     [DEPTH];
    alu_flags_t       flags_mem_q  [DEPTH];

    alu_flags_t       in_flags;
    alu_flags_t       head_flags;
    logic             push;
    logic             pop;

    alu_flags #(.WIDTH(WIDTH)) u_flags (
        .data  (in_result),
        .flags (in_flags)
    );

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            total_d  = total_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            result_mem_q[wr_ptr_q] <= in_result;
            op_mem_q[wr_ptr_q]     <= in_op;
            flags_mem_q[wr_ptr_q]  <= in_flags;
        end
    end

    always_comb begin
        out_result      = '0;
        out_op          = '0;
        head_flags      = '0;
        head_flags.zero = 1'b1;
        if (out_valid) begin
            out_result = result_mem_q[rd_ptr_q];
            out_op     = op_mem_q[rd_ptr_q];
            head_flags = flags_mem_q[rd_ptr_q];
        end
    end

    assign out_zero       = head_flags.zero;
    assign out_neg        = head_flags.neg;
    assign out_parity     = head_flags.parity;
    assign count          = count_q;
    assign accepted_total = total_q;

endmodule
